// File: rtl/alu_result_stage.sv
// ALU result stage: accepts results, keeps the accumulator and sticky error,
// and queues {data, zero, neg, err} entries in a small FIFO for the consumer.
module alu_result_stage #(
  parameter int n     = 16,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [n-1:0]               res_data,
  input  logic                       res_err,
  input  logic                       acc_load,
  input  logic                       acc_clr,
  output logic [n-1:0]               acc_val,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [n-1:0]               out_data,
  output logic                       out_zero,
  output logic                       out_neg,
  output logic                       out_err,
  output logic [$clog2(depth):0]     count,
  output logic                       err_sticky
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [n-1:0]     mem_data [depth];
  logic [depth-1:0] mem_zero;
  logic [depth-1:0] mem_neg;
  logic [depth-1:0] mem_err;
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Full refuses a push even when a pop happens in the same cycle.
  assign res_ready = (count != cw'(depth));
  assign out_valid = (count != '0);
  assign push      = res_valid & res_ready;
  assign pop       = out_valid & out_ready;

  assign out_data = out_valid ? mem_data[rd_ptr] : '0;
  assign out_zero = out_valid & mem_zero[rd_ptr];
  assign out_neg  = out_valid & mem_neg[rd_ptr];
  assign out_err  = out_valid & mem_err[rd_ptr];

  // Storage is not reset; out_valid gates stale contents after a reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= res_data;
      mem_zero[wr_ptr] <= (res_data == '0);
      mem_neg[wr_ptr]  <= res_data[n-1];
      mem_err[wr_ptr]  <= res_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      acc_val    <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
      case ({push, pop})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
      if (acc_clr)
        acc_val <= '0;
      else if (push && acc_load)
        acc_val <= res_data;
      // A new error in the same cycle as a clear must not be lost.
      if (push && res_err)
        err_sticky <= 1'b1;
      else if (acc_clr)
        err_sticky <= 1'b0;
    end
  end

  control_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({res_valid, out_ready, acc_load, acc_clr}));

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed pushes queue expected entries,
// a negedge monitor pops and compares every accepted output.
`timescale 1ns/1ps
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [15:0] res_data = '0;
  logic        res_err = 1'b0;
  logic        acc_load = 1'b0;
  logic        acc_clr = 1'b0;
  logic [15:0] acc_val;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_zero;
  logic        out_neg;
  logic        out_err;
  logic [2:0]  count;
  logic        err_sticky;

  typedef struct {
    logic [15:0] d;
    logic        z;
    logic        ng;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  alu_result_stage #(.n(16), .depth(4)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .acc_load(acc_load), .acc_clr(acc_clr),
    .acc_val(acc_val), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_neg(out_neg),
    .out_err(out_err), .count(count), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_pop", {16'h0, out_data}, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pop_data", {16'h0, out_data}, {16'h0, e.d});
        chk("pop_zero", {31'h0, out_zero}, {31'h0, e.z});
        chk("pop_neg",  {31'h0, out_neg},  {31'h0, e.ng});
        chk("pop_err",  {31'h0, out_err},  {31'h0, e.e});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] d, input logic e, input logic ld, input logic cl);
    bit acc;
    acc = 1'b0;
    res_valid = 1'b1; res_data = d; res_err = e; acc_load = ld; acc_clr = cl;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (res_ready) begin
        acc = 1'b1;
        q.push_back('{d, (d == 16'h0), d[15], e});
      end
      cyc();
    end
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
    res_valid = 1'b0; res_err = 1'b0; acc_load = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || count != 3'd0) && k < 100) begin
      cyc();
      k++;
    end
    if (k >= 100) chk("drain_timeout", 32'd0, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_count",  {29'h0, count}, 32'd0);
    chk("rst_ready",  {31'h0, res_ready}, 32'd1);
    chk("rst_valid",  {31'h0, out_valid}, 32'd0);
    chk("rst_acc",    {16'h0, acc_val}, 32'd0);
    chk("rst_sticky", {31'h0, err_sticky}, 32'd0);
    chk("rst_data",   {16'h0, out_data}, 32'd0);
    cyc();
    rst = 1'b0;

    // Reset in the middle of traffic
    push_one(16'h0001, 1'b0, 1'b0, 1'b0);
    push_one(16'h0002, 1'b0, 1'b0, 1'b0);
    push_one(16'h0003, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_acc", {16'h0, acc_val}, 32'h0003);
    #2 rst = 1'b1;
    #1;
    chk("midrst_count", {29'h0, count}, 32'd0);
    chk("midrst_valid", {31'h0, out_valid}, 32'd0);
    chk("midrst_acc",   {16'h0, acc_val}, 32'd0);
    chk("midrst_ready", {31'h0, res_ready}, 32'd1);
    q.delete();
    rst = 1'b0;
    push_one(16'h0042, 1'b0, 1'b0, 1'b0);
    chk("post_rst_head", {16'h0, out_data}, 32'h0042);
    chk("post_rst_count", {29'h0, count}, 32'd1);
    drain();

    // Fill, refuse while full, then wrap
    for (int i = 1; i <= 4; i++) push_one(16'(i), 1'b0, 1'b0, 1'b0);
    res_valid = 1'b1; res_data = 16'h0005;
    @(negedge clk);
    chk("full_ready", {31'h0, res_ready}, 32'd0);
    chk("full_count", {29'h0, count}, 32'd4);
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_ready", {31'h0, res_ready}, 32'd0);
    cyc();
    out_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_ready", {31'h0, res_ready}, 32'd1);
    chk("after_pop_count", {29'h0, count}, 32'd3);
    q.push_back('{16'h0005, 1'b0, 1'b0, 1'b0});
    cyc();
    res_valid = 1'b0;
    chk("refill_count", {29'h0, count}, 32'd4);
    drain();

    // Simultaneous push and pop at count 2
    push_one(16'h000A, 1'b0, 1'b0, 1'b0);
    push_one(16'h000B, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      res_valid = 1'b1; res_data = 16'h0010 + 16'(i); out_ready = 1'b1;
      @(negedge clk);
      chk("pp_count", {29'h0, count}, 32'd2);
      chk("pp_ready", {31'h0, res_ready}, 32'd1);
      if (res_ready) q.push_back('{16'h0010 + 16'(i), 1'b0, 1'b0, 1'b0});
      cyc();
    end
    res_valid = 1'b0; out_ready = 1'b0;
    chk("pp_end_count", {29'h0, count}, 32'd2);
    drain();

    // Accumulator
    push_one(16'h1234, 1'b0, 1'b1, 1'b0);
    chk("acc_load", {16'h0, acc_val}, 32'h1234);
    acc_load = 1'b1;
    cyc();
    acc_load = 1'b0;
    chk("acc_load_nopush", {16'h0, acc_val}, 32'h1234);
    push_one(16'h5678, 1'b0, 1'b0, 1'b0);
    chk("acc_noload", {16'h0, acc_val}, 32'h1234);
    push_one(16'h9ABC, 1'b0, 1'b1, 1'b1);
    chk("acc_clr_wins", {16'h0, acc_val}, 32'd0);
    chk("acc_clr_enq", {29'h0, count}, 32'd3);
    drain();

    // Flags and sticky error
    chk("sticky_clear", {31'h0, err_sticky}, 32'd0);
    push_one(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("head_zero", {31'h0, out_zero}, 32'd1);
    chk("head_neg0", {31'h0, out_neg}, 32'd0);
    push_one(16'h8001, 1'b0, 1'b0, 1'b0);
    push_one(16'hFFFF, 1'b1, 1'b0, 1'b0);
    chk("sticky_set", {31'h0, err_sticky}, 32'd1);
    drain();
    chk("sticky_hold", {31'h0, err_sticky}, 32'd1);
    acc_clr = 1'b1;
    cyc();
    acc_clr = 1'b0;
    chk("sticky_clr", {31'h0, err_sticky}, 32'd0);
    push_one(16'h0100, 1'b1, 1'b0, 1'b1);
    chk("sticky_set_wins", {31'h0, err_sticky}, 32'd1);
    drain();
    acc_clr = 1'b1;
    cyc();
    acc_clr = 1'b0;

    // Empty behaviour
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("empty_count", {29'h0, count}, 32'd0);
      chk("empty_data", {16'h0, out_data}, 32'd0);
      chk("empty_flags", {29'h0, out_zero, out_neg, out_err}, 32'd0);
      cyc();
    end
    push_one(16'h0077, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("single_popped", {29'h0, count}, 32'd0);
    chk("queue_empty", q.size(), 32'd0);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Output-side counterpart of the ALU input-register stage. Accepts completed ALU results over a valid/ready handshake, maintains the accumulator whose value feeds the input stage's `acc_val`, and buffers results with status flags in a small FIFO for a downstream consumer over a second valid/ready handshake.

## Interface

**Parameters**
- `n`, 16: data width.
- `depth`, 4: FIFO entries; power of two, at least 2.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `res_valid`, input, 1: ALU result offered.
- `res_ready`, output, 1: stage can accept a result.
- `res_data`, input, n: ALU result value.
- `res_err`, input, 1: result is invalid, e.g. divide by zero; qualified by `res_valid`.
- `acc_load`, input, 1: on accept, also write `res_data` into the accumulator.
- `acc_clr`, input, 1: clear the accumulator; independent of the handshake.
- `acc_val`, output, n: accumulator value, routed to the input stage.
- `out_valid`, output, 1: FIFO head available.
- `out_ready`, input, 1: consumer takes the head.
- `out_data`, output, n: FIFO head value.
- `out_zero`, output, 1: head value == 0.
- `out_neg`, output, 1: head value MSB.
- `out_err`, output, 1: head `res_err`.
- `count`, output, clog2(depth)+1: current FIFO occupancy.
- `err_sticky`, output, 1: set by any accepted result with `res_err`=1.

## Operation

- **Accept.** `push = res_valid & res_ready`. `res_ready = (count != depth)`. A full FIFO refuses a push even if a pop happens in the same cycle.
- **FIFO entry.** Each entry is {data, zero, neg, err}. Flags are computed from `res_data` at push time, not at read time.
- **Pop.** `pop = out_valid & out_ready`. `out_valid = (count != 0)`.
- **Empty outputs.** While empty, `out_data`, `out_zero`, `out_neg` and `out_err` are all 0.
- **Pointers.** Write and read pointers are clog2(depth) bits and wrap modulo `depth`.
- **Count.** Push only: +1. Pop only: −1. Push and pop together (possible only when not full): unchanged, with both pointers advancing.
- **Accumulator.**
  - `acc_clr` = 1 → accumulator becomes 0 at the next edge. This has priority over a push with `acc_load`, but that push is still enqueued.
  - Else if `push & acc_load` → accumulator becomes `res_data`, including results with `res_err`=1.
  - `acc_load` without a push has no effect.
- **Sticky error.** `err_sticky` is set at the edge of a push with `res_err`=1. It is cleared only by `acc_clr` or `rst`. When `acc_clr` and an erroring push occur in the same cycle, set wins.
- **Control values.** `res_valid`, `out_ready`, `acc_load` and `acc_clr` are assumed to be known (not X) whenever `rst` = 0. X on these is a verification error.
- **Structure.** FIFO storage is a register array. Outputs are driven from registers or from simple decode of the head entry; there are no combinational paths from `res_*` to `out_*`.

## Timing

- **Reset.**
  - `rst` high clears, immediately and asynchronously: pointers, `count`=0, `acc_val`=0, `err_sticky`=0.
  - Hence `res_ready`=1, `out_valid`=0, and `out_data`/`out_zero`/`out_neg`/`out_err`=0.
  - Reset in the middle of traffic discards all FIFO contents. The first push after deassertion lands at entry 0.
- **Latency.**
  - A result pushed at edge k is visible on `out_*` after edge k if the FIFO was empty; otherwise it appears after all earlier entries pop.
  - `acc_val` updates at edge k.
- **Throughput.** One push and one pop per cycle sustained, with no bubbles when the FIFO is neither full nor empty.
- **`res_ready` timing.** Deasserts in the cycle after the edge that makes `count` == `depth`. It reasserts in the cycle after the first pop from full.
- **Source rules.** The source holds `res_valid`/`res_data`/`res_err` stable until accepted. The stage does not check this.
- **Consumer rules.** The consumer may toggle `out_ready` freely. `out_*` stay stable while `out_valid` = 1 and no pop occurs.
- **`count` timing.** Registered; reflects state after the last edge.

## Test plan

1. **Reset mid-stream.** Push 3 results, then assert `rst` asynchronously, not on an edge → `count`=0, `out_valid`=0, `acc_val`=0 and `res_ready`=1 before the next edge. The next push of 0x0042 appears as the head.
2. **Fill and wrap.** Hold `out_ready`=0 and push 0x0001..0x0004. Then offer 0x0005 → `res_ready`=0 and the 5th value is not accepted. Pop one → 0x0005 is accepted. Drain order is 1,2,3,4,5, exercising pointer wrap.
3. **Simultaneous push/pop.** With `count`=2, hold `res_valid`=`out_ready`=1 for 10 cycles pushing 0x0010..0x0019 → `count` stays 2. Popped values are the two prior entries followed by 0x0010..0x0017, in order.
4. **Accumulator.**
   - Push 0x1234 with `acc_load`=1 → `acc_val`=0x1234.
   - Push 0x5678 with `acc_load`=0 → unchanged.
   - Same cycle: `acc_clr`=1 plus push 0x9ABC with `acc_load`=1 → `acc_val`=0 and 0x9ABC is enqueued.
5. **Flags.**
   - Push 0x0000 → head `out_zero`=1, `out_neg`=0.
   - Push 0x8001 → `out_zero`=0, `out_neg`=1.
   - Push 0xFFFF with `res_err`=1 → `out_err`=1 and `err_sticky`=1.
   - `err_sticky` stays 1 after the pop and clears only on `acc_clr`.
6. **Empty behaviour.** From empty, with `out_ready`=1 and no pushes → no underflow, `count` stays 0 and `out_data`=0. A single push then pops on the next cycle.
